// File: rtl/link_pkg.sv
// Shared link definitions: message type codes, frame geometry and scheduler state encoding.
// Also used by the link RX decoder and TX serializer.
package link_pkg;

  localparam logic [1:0] MSG_CONNECT = 2'd0;
  localparam logic [1:0] MSG_START   = 2'd1;
  localparam logic [1:0] MSG_FINISH  = 2'd2;
  localparam logic [1:0] MSG_CELL    = 2'd3;

  localparam int FRAME_W   = 14;
  localparam int PAYLOAD_W = 12;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SEND     = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;
  localparam logic [1:0] ST_RESP     = 2'd3;

  // Fixed priority: the lowest set request index wins.
  function automatic logic [1:0] lowest_req(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/link_ack_timer.sv
// Ack wait timer: cleared when a frame is accepted, counts while enabled,
// and flags expiry on its final count (ACK_TIMEOUT-1).
module link_ack_timer #(
  parameter int ACK_TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(ACK_TIMEOUT - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == LAST);

endmodule

// File: rtl/link_scheduler.sv
// Grants one of four link requesters at a time, offers its frame to the TX serializer,
// then waits for the peer's ack with timeout-driven retransmission.
module link_scheduler
  import link_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           req,
  input  logic [PAYLOAD_W-1:0] cell_payload,
  output logic [FRAME_W-1:0]   tx_frame,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic                 rx_ack,
  input  logic [1:0]           rx_ack_type,
  output logic [3:0]           done,
  output logic [3:0]           fail,
  output logic                 busy,
  output logic                 link_error
);

  localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

  logic [1:0]         state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic [3:0]         done_q, done_d;
  logic [3:0]         fail_q, fail_d;
  logic               link_error_q, link_error_d;
  logic               timer_clear;
  logic               timer_expire;

  link_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (state_q == ST_WAIT_ACK),
    .expire (timer_expire)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    frame_d      = frame_q;
    retry_d      = retry_q;
    done_d       = 4'b0000;
    fail_d       = 4'b0000;
    link_error_d = link_error_q;
    timer_clear  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          idx_d   = lowest_req(req);
          frame_d = {idx_d, (idx_d == MSG_CELL) ? cell_payload : {PAYLOAD_W{1'b0}}};
          retry_d = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          timer_clear = 1'b1;
          state_d     = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // A matching ack wins over a simultaneous timer expiry.
        if (rx_ack && (rx_ack_type == frame_q[FRAME_W-1 -: 2])) begin
          done_d  = 4'b0001 << idx_q;
          state_d = ST_RESP;
        end else if (timer_expire) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_SEND;
          end else begin
            fail_d       = 4'b0001 << idx_q;
            link_error_d = 1'b1;
            state_d      = ST_RESP;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= 2'd0;
      frame_q      <= '0;
      retry_q      <= '0;
      done_q       <= 4'b0000;
      fail_q       <= 4'b0000;
      link_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      retry_q      <= retry_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      link_error_q <= link_error_d;
    end
  end

  assign tx_frame   = frame_q;
  assign tx_valid   = (state_q == ST_SEND);
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign fail       = fail_q;
  assign link_error = link_error_q;

endmodule

// File: doc/link_scheduler.md
# link_scheduler

Arbitrates the board-to-board link between the four message sources of the two-player game: connect, start, game-finish and cell-update. It grants one requester at a time and hands that requester's frame to the serial transmitter through a valid/ready handshake. It then waits for the peer's acknowledge and retransmits on timeout. It sits between the stage controller and game logic on one side and the link TX serializer and RX decoder on the other.

## Interface
- ACK_TIMEOUT, 1000000: cycles to wait for a peer ack after a frame is accepted (10 ms at 100 MHz); must be ≥ 2.
- MAX_RETRY, 3: retransmissions allowed after the first send before declaring failure.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req  input  4  level requests; bit 0 connect, 1 start, 2 game_finish, 3 cell_update; held until done/fail.
- cell_payload  input  12  {row[3:0], col[3:0], value[3:0]}, valid while req[3] is high.
- tx_frame  output  14  {type[1:0], payload[11:0]}; payload is zero for types 0–2.
- tx_valid  output  1  frame offered to serializer.
- tx_ready  input  1  serializer accepts the frame when tx_valid & tx_ready.
- rx_ack  input  1  one-cycle pulse: peer ack frame decoded.
- rx_ack_type  input  2  message type the ack refers to.
- done  output  4  one-cycle pulse to the served requester on successful ack.
- fail  output  4  one-cycle pulse to the served requester after retries are exhausted.
- busy  output  1  high in any state except IDLE.
- link_error  output  1  sticky; set on any fail; cleared only by reset.

## Operation
- States: IDLE, SEND, WAIT_ACK, RESP.
- IDLE: if req ≠ 0, grant the lowest set index (fixed priority 0 > 1 > 2 > 3). Latch the grant index, type = index, payload (cell_payload for index 3, else 0). Clear the retry count. Go to SEND.
- SEND: tx_valid = 1. tx_frame is stable from the latched registers. On tx_valid & tx_ready, clear the ack timer and go to WAIT_ACK.
- WAIT_ACK: the timer counts up each cycle.
  - rx_ack with rx_ack_type equal to the latched type: success, go to RESP with done.
  - Timer reaches ACK_TIMEOUT−1 with no matching ack: if retry < MAX_RETRY, retry++ and return to SEND with the same frame; else go to RESP with fail.
- RESP: one cycle. Exactly one bit of done or fail is set, at the latched index. link_error is set on fail. Then go to IDLE.
- Acks are ignored outside WAIT_ACK. Acks with a non-matching type are ignored.
- A matching ack in the same cycle as timer expiry counts as success.
- If req drops mid-transaction, the transaction still completes and done/fail still pulses.
- Requesters deassert req the cycle after seeing done or fail. Because RESP sits between completion and IDLE, the same request is never double-granted.
- Reset, including mid-transaction: state IDLE; tx_valid 0, tx_frame 0, done 0, fail 0, busy 0, link_error 0; timer and retry count 0.

## Timing
- req rises in IDLE at cycle t → tx_valid = 1 at t+1.
- tx_ready already high at t+1 → transfer at t+1, WAIT_ACK at t+2.
- Matching ack at cycle a → done at a+1 (RESP), IDLE at a+2.
- Timeout: with the frame accepted at cycle s, expiry is in cycle s+ACK_TIMEOUT and SEND is re-entered at s+ACK_TIMEOUT+1.
- Worst-case fail latency ≈ (MAX_RETRY+1)·(ACK_TIMEOUT+1) cycles plus serializer stalls.
- No combinational path from inputs to any output. All outputs are registered or decoded from state registers.

## Structure
- Shared package link_pkg:
  - type codes MSG_CONNECT=2'd0, MSG_START=2'd1, MSG_FINISH=2'd2, MSG_CELL=2'd3;
  - FRAME_W=14, PAYLOAD_W=12;
  - state encoding.
  - The RX decoder and TX serializer also use this package.
- Sub-module link_ack_timer: counter with clear and enable; outputs expire at ACK_TIMEOUT−1; width $clog2(ACK_TIMEOUT).

## Test plan
Run with ACK_TIMEOUT=8 and MAX_RETRY=2.
- Basic connect: req=4'b0001, tx_ready=1, ack type 0 three cycles after transfer → tx_frame=14'h0000; done=4'b0001 for exactly one cycle; busy falls afterwards.
- Priority: req=4'b1010 together → start is served first (tx_frame type 1); cell is served after start's done, with payload latched (row 5, col 7, value 9 → 14'h3579).
- Backpressure: tx_ready low for 5 cycles → tx_valid held high and tx_frame stable for all 5; the timer does not run until the transfer.
- Retry then succeed: no ack on the first send → a second send exactly 9 cycles after the first transfer; matching ack → done; link_error stays 0.
- Exhausted: never ack → 3 transfers total, then fail=4'b0100 for one cycle and link_error=1 until reset.
- Wrong-type ack and collision: ack type 2 while waiting on type 1 → ignored. A matching ack on the expiry cycle → done with no resend. Reset asserted in WAIT_ACK → all outputs 0 next cycle.
